// File: rtl/amba_axi_pkg.sv
`default_nettype none
// ============================================================================
// amba_axi_pkg : AXI4 bus widths, burst/response encodings and channel bundles
// Revision     : 1.0
// ============================================================================
package amba_axi_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    axi_burst_t                awburst;
    logic                      awvalid;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [AXI_STRB_WIDTH-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      bready;
    logic [AXI_ID_WIDTH-1:0]   arid;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    axi_burst_t                arburst;
    logic                      arvalid;
    logic                      rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                      awready;
    logic                      wready;
    logic [AXI_ID_WIDTH-1:0]   bid;
    axi_resp_t                 bresp;
    logic                      bvalid;
    logic                      arready;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    axi_resp_t                 rresp;
    logic                      rlast;
    logic                      rvalid;
  } s_axi_miso_t;

endpackage
`default_nettype wire

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// dma_pkg  : DMA-side shared types (per-channel AXI burst context)
// Revision : 1.0
// ============================================================================
package dma_pkg;
  import amba_axi_pkg::*;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    axi_burst_t                burst;
    logic [7:0]                beat_cnt;
    logic                      err;
  } axi_burst_ctx_t;

endpackage
`default_nettype wire

// File: rtl/dma_axi_burst_addr.sv
`default_nettype none
// ============================================================================
// dma_axi_burst_addr : beat address step, word index and range/legality flags
// Revision           : 1.0
// ============================================================================
module dma_axi_burst_addr
  import amba_axi_pkg::*;
#(
  parameter int                        MEM_WORDS = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic [AXI_ADDR_WIDTH-1:0]    addr,
  input  logic [2:0]                   size,
  input  axi_burst_t                   burst,
  output logic [AXI_ADDR_WIDTH-1:0]    next_addr,
  output logic [$clog2(MEM_WORDS)-1:0] idx,
  output logic                         out_of_range,
  output logic                         unsupported
);

  localparam int LG_BYTES = $clog2(AXI_DATA_WIDTH / 8);

  logic [AXI_ADDR_WIDTH-1:0] word;

  assign word         = (addr - BASE_ADDR) >> LG_BYTES;
  assign idx          = word[$clog2(MEM_WORDS)-1:0];
  assign out_of_range = (addr < BASE_ADDR) || (word >= AXI_ADDR_WIDTH'(MEM_WORDS));
  // WRAP and reserved bursts still step like INCR; they are only flagged.
  assign unsupported  = (size > 3'(LG_BYTES)) || (burst == AXI_BURST_WRAP) ||
                        (burst == AXI_BURST_RSVD);
  assign next_addr    = (burst == AXI_BURST_FIXED) ? addr
                                                   : addr + (AXI_ADDR_WIDTH'(1) << size);

endmodule
`default_nettype wire

// File: rtl/dma_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// dma_axi_mem_slave : AXI4 responder RAM, one outstanding burst per direction
// Revision          : 1.0
// ============================================================================
module dma_axi_mem_slave
  import amba_axi_pkg::*;
  import dma_pkg::*;
#(
  parameter int                        MEM_WORDS = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  s_axi_mosi_t                  axi_mosi_i,
  output s_axi_miso_t                  axi_miso_o,
  input  logic                         bkdr_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] bkdr_idx_i,
  input  logic [AXI_DATA_WIDTH-1:0]    bkdr_wdata_i,
  output logic [AXI_DATA_WIDTH-1:0]    bkdr_rdata_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  wr_state_t      wr_state, wr_next;
  rd_state_t      rd_state, rd_next;
  axi_burst_ctx_t wr_ctx, wr_ctx_next, rd_ctx, rd_ctx_next;

  logic                      awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rlast_q;
  logic [AXI_ID_WIDTH-1:0]   bid_q, rid_q;
  axi_resp_t                 bresp_q, rresp_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  logic [AXI_ADDR_WIDTH-1:0] wr_next_addr, rd_next_addr, rd_addr_in;
  logic [IDX_W-1:0]          wr_idx, rd_idx;
  logic                      wr_oor, wr_unsup, rd_oor, rd_unsup;
  logic [2:0]                rd_size_in;
  axi_burst_t                rd_burst_in;
  logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_last_beat, mem_we, rd_load;

  // Write side always evaluates the beat currently being accepted.
  dma_axi_burst_addr #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) u_wr_addr (
    .addr(wr_ctx.addr), .size(wr_ctx.size), .burst(wr_ctx.burst),
    .next_addr(wr_next_addr), .idx(wr_idx), .out_of_range(wr_oor), .unsupported(wr_unsup)
  );

  // Read side evaluates the beat about to be loaded into the R register:
  // the AR address at acceptance, afterwards the stored next-beat address.
  assign rd_addr_in  = (rd_state == R_IDLE) ? axi_mosi_i.araddr  : rd_ctx.addr;
  assign rd_size_in  = (rd_state == R_IDLE) ? axi_mosi_i.arsize  : rd_ctx.size;
  assign rd_burst_in = (rd_state == R_IDLE) ? axi_mosi_i.arburst : rd_ctx.burst;

  dma_axi_burst_addr #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) u_rd_addr (
    .addr(rd_addr_in), .size(rd_size_in), .burst(rd_burst_in),
    .next_addr(rd_next_addr), .idx(rd_idx), .out_of_range(rd_oor), .unsupported(rd_unsup)
  );

  assign aw_hs        = axi_mosi_i.awvalid & awready_q;
  assign w_hs         = axi_mosi_i.wvalid & wready_q;
  assign b_hs         = bvalid_q & axi_mosi_i.bready;
  assign ar_hs        = axi_mosi_i.arvalid & arready_q;
  assign r_hs         = rvalid_q & axi_mosi_i.rready;
  assign wr_last_beat = (wr_ctx.beat_cnt == wr_ctx.len);
  assign mem_we       = w_hs & ~wr_oor & ~rst;
  assign rd_load      = ar_hs | (r_hs & ~rlast_q);

  always_comb begin
    wr_next     = wr_state;
    wr_ctx_next = wr_ctx;
    case (wr_state)
      W_IDLE: if (aw_hs) begin
        wr_next              = W_DATA;
        wr_ctx_next.id       = axi_mosi_i.awid;
        wr_ctx_next.addr     = axi_mosi_i.awaddr;
        wr_ctx_next.len      = axi_mosi_i.awlen;
        wr_ctx_next.size     = axi_mosi_i.awsize;
        wr_ctx_next.burst    = axi_mosi_i.awburst;
        wr_ctx_next.beat_cnt = '0;
        wr_ctx_next.err      = 1'b0;
      end
      W_DATA: if (w_hs) begin
        wr_ctx_next.addr     = wr_next_addr;
        wr_ctx_next.beat_cnt = wr_ctx.beat_cnt + 8'd1;
        wr_ctx_next.err      = wr_ctx.err | wr_oor | wr_unsup |
                               (axi_mosi_i.wlast != wr_last_beat);
        if (wr_last_beat) wr_next = W_RESP;
      end
      W_RESP: if (b_hs) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next     = rd_state;
    rd_ctx_next = rd_ctx;
    case (rd_state)
      R_IDLE: if (ar_hs) begin
        rd_next              = R_DATA;
        rd_ctx_next.id       = axi_mosi_i.arid;
        rd_ctx_next.addr     = rd_next_addr;
        rd_ctx_next.len      = axi_mosi_i.arlen;
        rd_ctx_next.size     = axi_mosi_i.arsize;
        rd_ctx_next.burst    = axi_mosi_i.arburst;
        rd_ctx_next.beat_cnt = '0;
        rd_ctx_next.err      = rd_unsup;
      end
      R_DATA: if (r_hs) begin
        if (rlast_q) begin
          rd_next = R_IDLE;
        end else begin
          rd_ctx_next.addr     = rd_next_addr;
          rd_ctx_next.beat_cnt = rd_ctx.beat_cnt + 8'd1;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      wr_ctx    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      wr_state  <= wr_next;
      wr_ctx    <= wr_ctx_next;
      awready_q <= (wr_next == W_IDLE);
      wready_q  <= (wr_next == W_DATA);
      bvalid_q  <= (wr_next == W_RESP);
      if (wr_next == W_RESP) begin
        bid_q   <= wr_ctx_next.id;
        bresp_q <= wr_ctx_next.err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      rd_ctx    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      rd_state  <= rd_next;
      rd_ctx    <= rd_ctx_next;
      arready_q <= (rd_next == R_IDLE);
      rvalid_q  <= (rd_next == R_DATA);
      // R payload only changes on a load, so it holds while stalled.
      if (rd_load) begin
        rid_q   <= rd_ctx_next.id;
        rdata_q <= rd_oor ? '0 : mem[rd_idx];
        rresp_q <= (rd_oor | rd_ctx_next.err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rlast_q <= (rd_ctx_next.beat_cnt == rd_ctx_next.len);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bkdr_we_i && !(mem_we && (wr_idx == bkdr_idx_i)))
      mem[bkdr_idx_i] <= bkdr_wdata_i;
    if (mem_we) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (axi_mosi_i.wstrb[b]) mem[wr_idx][b*8 +: 8] <= axi_mosi_i.wdata[b*8 +: 8];
      end
    end
  end

  assign bkdr_rdata_o = mem[bkdr_idx_i];

  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = awready_q;
    axi_miso_o.wready  = wready_q;
    axi_miso_o.bid     = bid_q;
    axi_miso_o.bresp   = bresp_q;
    axi_miso_o.bvalid  = bvalid_q;
    axi_miso_o.arready = arready_q;
    axi_miso_o.rid     = rid_q;
    axi_miso_o.rdata   = rdata_q;
    axi_miso_o.rresp   = rresp_q;
    axi_miso_o.rlast   = rlast_q;
    axi_miso_o.rvalid  = rvalid_q;
  end

endmodule
`default_nettype wire
